// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST packet sanitizer.
package avst_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    PKT_S  = 2'd1,
    DROP_S = 2'd2
  } state_e;

  // True when adding inc to cnt would pass max_val; callers then pin the count at max_val.
  function automatic logic sat_would_exceed(input logic [63:0] cnt,
                                            input logic [63:0] inc,
                                            input logic [63:0] max_val);
    return (cnt + inc) > max_val;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import avst_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (sat_would_exceed(64'(cnt_o), 64'(inc_i), 64'({CNT_WIDTH{1'b1}}))) begin
      cnt_o <= '1;
    end else begin
      cnt_o <= cnt_o + CNT_WIDTH'(inc_i);
    end
  end

endmodule

// File: rtl/avst_pkt_sanitizer.sv
// Avalon-ST framing sanitizer: forwards only 2..MAX_PKT_LEN word packets with clean SOP/EOP.
// state  | meaning
// IDLE_S | between packets, waiting for a SOP
// PKT_S  | packet open, its latest word sits in the hold register
// DROP_S | packet truncated, discarding words up to the original EOP
module avst_pkt_sanitizer
  import avst_pkg::*;
#(
  parameter int DWIDTH      = 16,
  parameter int MAX_PKT_LEN = 13,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DWIDTH-1:0]    snk_data_i,
  input  logic                 snk_startofpacket_i,
  input  logic                 snk_endofpacket_i,
  input  logic                 snk_valid_i,
  output logic                 snk_ready_o,
  output logic [DWIDTH-1:0]    src_data_o,
  output logic                 src_startofpacket_o,
  output logic                 src_endofpacket_o,
  output logic                 src_valid_o,
  input  logic                 src_ready_i,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [CNT_WIDTH-1:0] trunc_cnt_o,
  output logic [CNT_WIDTH-1:0] unterm_cnt_o
);

  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
  } word_t;

  state_e           state, state_nxt;
  word_t            hold, hold_nxt, in_word;
  logic             hold_valid, hold_valid_nxt;
  logic [LEN_W-1:0] len, len_nxt, len_inc;
  logic             out_free, accept, release_h, force_eop;
  logic [1:0]       drop_inc;
  logic             trunc_inc, unterm_inc, pkt_inc;

  assign out_free    = !src_valid_o || src_ready_i;
  assign snk_ready_o = out_free && !(hold_valid && hold.eop);
  assign accept      = snk_valid_i && snk_ready_o;
  assign in_word     = {snk_data_i, snk_startofpacket_i, snk_endofpacket_i};
  assign len_inc     = (len == LEN_MAX) ? len : len + LEN_ONE;
  assign pkt_inc     = src_valid_o && src_ready_i && src_endofpacket_o;

  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    hold_valid_nxt = hold_valid;
    len_nxt        = len;
    release_h      = 1'b0;
    force_eop      = 1'b0;
    drop_inc       = 2'd0;
    trunc_inc      = 1'b0;
    unterm_inc     = 1'b0;

    // A finished packet in hold leaves on its own; input stalls for that cycle.
    if (hold_valid && hold.eop && out_free) begin
      release_h      = 1'b1;
      hold_valid_nxt = 1'b0;
    end

    if (accept) begin
      case (state)
        PKT_S: begin
          if (in_word.sop) begin
            hold_valid_nxt = 1'b0;
            if (len == LEN_ONE) begin
              drop_inc = 2'd1;
            end else begin
              release_h  = 1'b1;
              force_eop  = 1'b1;
              unterm_inc = 1'b1;
            end
            // A SOP+EOP word here is a one-word packet and goes too.
            if (in_word.eop) begin
              drop_inc  = drop_inc + 2'd1;
              state_nxt = IDLE_S;
            end else begin
              hold_nxt       = in_word;
              hold_valid_nxt = 1'b1;
              len_nxt        = LEN_ONE;
            end
          end else begin
            release_h      = 1'b1;
            hold_nxt       = in_word;
            hold_valid_nxt = 1'b1;
            len_nxt        = len_inc;
            if (in_word.eop) begin
              state_nxt = IDLE_S;
            end else if (len_inc == LEN_MAX) begin
              hold_nxt.eop = 1'b1;
              trunc_inc    = 1'b1;
              state_nxt    = DROP_S;
            end
          end
        end
        default: begin
          if (in_word.sop && !in_word.eop) begin
            hold_nxt       = in_word;
            hold_valid_nxt = 1'b1;
            len_nxt        = LEN_ONE;
            state_nxt      = PKT_S;
          end else begin
            drop_inc = 2'd1;
            if (in_word.sop || in_word.eop) state_nxt = IDLE_S;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= IDLE_S;
      hold                <= '0;
      hold_valid          <= 1'b0;
      len                 <= '0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_valid_o         <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      hold_valid <= hold_valid_nxt;
      len        <= len_nxt;
      if (out_free) begin
        src_valid_o <= release_h;
        if (release_h) begin
          src_data_o          <= hold.data;
          src_startofpacket_o <= hold.sop;
          src_endofpacket_o   <= hold.eop || force_eop;
        end
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_pkt_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(pkt_inc), .cnt_o(pkt_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(2)) u_drop_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(drop_inc), .cnt_o(drop_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_trunc_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(trunc_inc), .cnt_o(trunc_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_unterm_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(unterm_inc), .cnt_o(unterm_cnt_o)
  );

endmodule

// File: tb/tb_avst_pkt_sanitizer.sv
// Self-checking bench for avst_pkt_sanitizer against a packet-level reference model.
module tb_avst_pkt_sanitizer;

  localparam int DW   = 16;
  localparam int MAXL = 13;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] snk_data;
  logic          snk_sop, snk_eop, snk_valid, snk_ready;
  logic [DW-1:0] src_data;
  logic          src_sop, src_eop, src_valid, src_ready;
  logic [CW-1:0] pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt;

  avst_pkt_sanitizer #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
    .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
    .src_data_o(src_data), .src_startofpacket_o(src_sop), .src_endofpacket_o(src_eop),
    .src_valid_o(src_valid), .src_ready_i(src_ready),
    .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt), .trunc_cnt_o(trunc_cnt), .unterm_cnt_o(unterm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } word_t;

  int    errors = 0;
  int    checks = 0;
  word_t got_q[$];
  word_t exp_q[$];
  word_t pend_q[$];
  int    mode = 0;       // 0 between packets, 1 in packet, 2 discarding after truncation
  int    m_pkt = 0, m_drop = 0, m_trunc = 0, m_unterm = 0;
  int    ready_mode = 0; // 0 always ready, 1 random, 2 alternating

  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = ($urandom_range(0, 3) != 0);
        default: src_ready = !src_ready;
      endcase
    end
  end

  // Everything is driven just after posedge, so at negedge valid&&ready predicts the next transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && src_valid && src_ready) got_q.push_back({src_data, src_sop, src_eop});
    end
  end

  task automatic model_emit();
    foreach (pend_q[i]) begin
      word_t o;
      o     = pend_q[i];
      o.sop = (i == 0);
      o.eop = (i == pend_q.size() - 1);
      exp_q.push_back(o);
    end
    m_pkt++;
    pend_q.delete();
  endtask

  task automatic model_word(input word_t w);
    if (w.sop) begin
      if (mode == 1) begin
        if (pend_q.size() == 1) m_drop++;
        else begin
          m_unterm++;
          model_emit();
        end
      end
      pend_q.delete();
      if (w.eop) begin
        m_drop++;
        mode = 0;
      end else begin
        pend_q.push_back(w);
        mode = 1;
      end
    end else if (mode == 1) begin
      pend_q.push_back(w);
      if (w.eop) begin
        model_emit();
        mode = 0;
      end else if (pend_q.size() == MAXL) begin
        model_emit();
        m_trunc++;
        mode = 2;
      end
    end else begin
      m_drop++;
      if (w.eop) mode = 0;
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    got_q.delete();
    exp_q.delete();
    mode = 0;
    m_pkt = 0; m_drop = 0; m_trunc = 0; m_unterm = 0;
  endtask

  task automatic send_word(input int d, input logic s, input logic e);
    int waited = 0;
    snk_data  = DW'(d);
    snk_sop   = s;
    snk_eop   = e;
    snk_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!snk_ready && waited < 300);
    if (!snk_ready) begin
      checks++;
      errors++;
      $display("FAIL send_word: snk_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      model_word({DW'(d), s, e});
    end
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    idle_cycles(4);
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s drain: got %0d words, required %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    snk_valid = 1'b0; snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0;
    idle_cycles(3);
    checks++;
    if ({src_valid, src_sop, src_eop, src_data} !== '0) begin
      errors++;
      $display("FAIL reset_src: got v=%b s=%b e=%b d=%h, required all 0", src_valid, src_sop, src_eop, src_data);
    end
    checks++;
    if ({pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d, required 0/0/0/0", pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt);
    end
    rst = 1'b0;
    idle_cycles(1);
    checks++;
    if (snk_ready !== 1'b1 || src_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got snk_ready=%b src_valid=%b, required 1 and 0", snk_ready, src_valid);
    end
  endtask

  task automatic test_clean();
    int b_pkt = m_pkt;
    send_word(5, 1, 0); send_word(3, 0, 0); send_word(9, 0, 0); send_word(1, 0, 1);
    wait_drain("clean");
    checks++;
    if (got_q.size() !== 4 || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL clean_len: got %0d words, required 4 (model %0d)", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clean_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_cnt !== CW'(b_pkt + 1) || {drop_cnt, trunc_cnt, unterm_cnt} !== '0) begin
      errors++;
      $display("FAIL clean_cnt: got pkt=%0d drop=%0d trunc=%0d unterm=%0d, required %0d/0/0/0", pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt, b_pkt + 1);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stray();
    int b_drop = m_drop;
    send_word(7, 0, 0); send_word(8, 0, 0); send_word(2, 1, 0); send_word(4, 0, 1);
    wait_drain("stray");
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL stray_len: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stray_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (drop_cnt !== CW'(b_drop + 2) || pkt_cnt !== CW'(m_pkt)) begin
      errors++;
      $display("FAIL stray_cnt: got drop=%0d pkt=%0d, required %0d/%0d", drop_cnt, pkt_cnt, b_drop + 2, m_pkt);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_truncate();
    int b_drop  = m_drop;
    int b_trunc = m_trunc;
    for (int i = 1; i <= 15; i++) send_word(i, i == 1, i == 15);
    wait_drain("trunc");
    checks++;
    if (got_q.size() !== MAXL || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL trunc_len: got %0d words, required %0d", got_q.size(), MAXL);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL trunc_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (trunc_cnt !== CW'(b_trunc + 1) || drop_cnt !== CW'(b_drop + 2)) begin
      errors++;
      $display("FAIL trunc_cnt: got trunc=%0d drop=%0d, required %0d/%0d", trunc_cnt, drop_cnt, b_trunc + 1, b_drop + 2);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_unterminated();
    int b_unterm = m_unterm;
    int b_pkt    = m_pkt;
    send_word(6, 1, 0); send_word(5, 0, 0); send_word(3, 1, 0); send_word(2, 0, 1);
    wait_drain("unterm");
    checks++;
    if (got_q.size() !== 4 || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL unterm_len: got %0d words, required 4", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL unterm_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (unterm_cnt !== CW'(b_unterm + 1) || pkt_cnt !== CW'(b_pkt + 2)) begin
      errors++;
      $display("FAIL unterm_cnt: got unterm=%0d pkt=%0d, required %0d/%0d", unterm_cnt, pkt_cnt, b_unterm + 1, b_pkt + 2);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_word();
    int b_drop = m_drop;
    send_word(9, 1, 1); send_word(4, 1, 0); send_word(1, 0, 1);
    wait_drain("single");
    checks++;
    if (got_q.size() !== 2 || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL single_len: got %0d words, required 2", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (drop_cnt !== CW'(b_drop + 1) || pkt_cnt !== CW'(m_pkt)) begin
      errors++;
      $display("FAIL single_cnt: got drop=%0d pkt=%0d, required %0d/%0d", drop_cnt, pkt_cnt, b_drop + 1, m_pkt);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    ready_mode = 2;
    fork
      begin
        send_word(11, 1, 0); send_word(12, 0, 0); send_word(13, 0, 0); send_word(14, 0, 1);
      end
      begin
        word_t prev = '0;
        logic  stalled = 1'b0;
        repeat (24) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (src_valid !== 1'b1 || {src_data, src_sop, src_eop} !== prev) begin
              errors++;
              $display("FAIL bp_stable: got v=%b word=%h, required v=1 word=%h", src_valid, {src_data, src_sop, src_eop}, prev);
            end
          end
          stalled = src_valid && !src_ready;
          if (stalled) stalls++;
          prev = {src_data, src_sop, src_eop};
        end
      end
    join
    wait_drain("bp");
    ready_mode = 0;
    checks++;
    if (stalls == 0) begin
      errors++;
      $display("FAIL bp_stalls: got %0d stalled cycles, required at least 1", stalls);
    end
    checks++;
    if (got_q.size() !== 4 || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bp_len: got %0d words, required 4", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    send_word(21, 1, 0); send_word(22, 0, 0); send_word(23, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({src_valid, src_sop, src_eop, src_data} !== '0 || {pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b s=%b e=%b d=%h pkt=%0d drop=%0d, required all 0", src_valid, src_sop, src_eop, src_data, pkt_cnt, drop_cnt);
    end
    model_reset();
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    send_word(31, 1, 0); send_word(32, 0, 0); send_word(33, 0, 1);
    wait_drain("rst_mid");
    checks++;
    if (got_q.size() !== 3 || got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rst_mid_len: got %0d words, required 3", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_cnt !== CW'(1) || {drop_cnt, trunc_cnt, unterm_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid_cnt: got pkt=%0d drop=%0d trunc=%0d unterm=%0d, required 1/0/0/0", pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int n = 0; n < 400; n++) begin
      idle_cycles($urandom_range(0, 2));
      send_word(int'($urandom_range(0, 65535)), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
    end
    // Closes whatever is open so the hold register drains.
    send_word(16'hbeef, 1'b0, 1'b1);
    wait_drain("random");
    ready_mode = 0;
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_len: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt} !== {CW'(m_pkt), CW'(m_drop), CW'(m_trunc), CW'(m_unterm)}) begin
      errors++;
      $display("FAIL rand_cnt: got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d", pkt_cnt, drop_cnt, trunc_cnt, unterm_cnt, m_pkt, m_drop, m_trunc, m_unterm);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stray();
    test_truncate();
    test_unterminated();
    test_single_word();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
